// File: rtl/operand_fetch.sv
// Decode-stage operand fetch: drives regfile reads, forwards EX/MEM results,
// stalls on load-use hazards and registers resolved operands toward EX.
module operand_fetch #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int OP_W   = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic              in_re1,
    input  logic              in_re2,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_wreg,
    input  logic [ADDR_W-1:0] in_wd,
    input  logic              in_is_load,
    output logic              re1,
    output logic [ADDR_W-1:0] raddr1,
    input  logic [DATA_W-1:0] rdata1,
    output logic              re2,
    output logic [ADDR_W-1:0] raddr2,
    input  logic [DATA_W-1:0] rdata2,
    input  logic              ex_wreg,
    input  logic [ADDR_W-1:0] ex_wd,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              ex_is_load,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [DATA_W-1:0] out_opnd1,
    output logic [DATA_W-1:0] out_opnd2,
    output logic              out_wreg,
    output logic [ADDR_W-1:0] out_wd,
    output logic              out_is_load,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              hazard;
    logic              advance;
    logic              take;
    logic [DATA_W-1:0] opnd1;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] opnd2;

    // A load still in EX has no data yet, so it is never a forwarding source.
    function automatic logic [DATA_W-1:0] resolve(
        input logic              used,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] rdata,
        input logic              exw,
        input logic [ADDR_W-1:0] exd,
        input logic [DATA_W-1:0] exdata,
        input logic              exld,
        input logic              memw,
        input logic [ADDR_W-1:0] memd,
        input logic [DATA_W-1:0] memdata
    );
        logic [DATA_W-1:0] v;
        if (!used || addr == '0)
            v = '0;
        else if (exw && exd == addr && !exld)
            v = exdata;
        else if (memw && memd == addr)
            v = memdata;
        else
            v = rdata;
        return v;
    endfunction

    assign re1    = in_valid & in_re1;
    assign raddr1 = in_rs;
    assign re2    = in_valid & in_re2 & ~in_use_imm;
    assign raddr2 = in_rt;

    assign hazard = in_valid & ex_wreg & ex_is_load & (ex_wd != '0) &
                    ((re1 & (ex_wd == in_rs)) | (re2 & (ex_wd == in_rt)));

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance & ~hazard & ~flush;
    assign take     = in_valid & in_ready;

    always_comb begin
        opnd1  = resolve(re1, in_rs, rdata1, ex_wreg, ex_wd, ex_wdata, ex_is_load,
                         mem_wreg, mem_wd, mem_wdata);
        rt_val = resolve(re2, in_rt, rdata2, ex_wreg, ex_wd, ex_wdata, ex_is_load,
                         mem_wreg, mem_wd, mem_wdata);
        opnd2  = in_use_imm ? in_imm : rt_val;
    end

    // Output stage holds while EX backpressures; a free slot with nothing accepted becomes a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_op      <= '0;
            out_opnd1   <= '0;
            out_opnd2   <= '0;
            out_wreg    <= 1'b0;
            out_wd      <= '0;
            out_is_load <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (advance) begin
            out_valid <= take;
            if (take) begin
                out_op      <= in_op;
                out_opnd1   <= opnd1;
                out_opnd2   <= opnd2;
                out_wreg    <= in_wreg;
                out_wd      <= in_wd;
                out_is_load <= in_is_load;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (hazard && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized scoreboard bench for operand_fetch: a stimulus process pushes expected
// results computed from a register-file model; a monitor pops them as EX consumes.
module tb_operand_fetch;

    typedef struct packed {
        logic        v, flush, ordy, re1, re2, use_imm, wreg, is_load;
        logic [7:0]  op;
        logic [4:0]  rs, rt, wd;
        logic [31:0] imm;
        logic        exw;
        logic [4:0]  exwd;
        logic [31:0] exdata;
        logic        exld;
        logic        memw;
        logic [4:0]  memwd;
        logic [31:0] memdata;
    } stim_t;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] opnd1, opnd2;
        logic        wreg;
        logic [4:0]  wd;
        logic        is_load;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [7:0]  in_op;
    logic        in_re1, in_re2, in_use_imm, in_wreg, in_is_load;
    logic [4:0]  in_rs, in_rt, in_wd;
    logic [31:0] in_imm;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        ex_wreg, ex_is_load, mem_wreg;
    logic [4:0]  ex_wd, mem_wd;
    logic [31:0] ex_wdata, mem_wdata;
    logic        out_valid, out_ready, out_wreg, out_is_load;
    logic [7:0]  out_op;
    logic [31:0] out_opnd1, out_opnd2;
    logic [4:0]  out_wd;
    logic [3:0]  stall_cnt;

    logic [31:0] regs [32];
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    bit          running = 0;
    bit          occ = 0;
    int          modelStall = 0;

    operand_fetch #(.DATA_W(32), .ADDR_W(5), .OP_W(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_re1(in_re1), .in_re2(in_re2), .in_rs(in_rs), .in_rt(in_rt),
        .in_use_imm(in_use_imm), .in_imm(in_imm), .in_wreg(in_wreg), .in_wd(in_wd),
        .in_is_load(in_is_load),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
        .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_opnd1(out_opnd1), .out_opnd2(out_opnd2), .out_wreg(out_wreg),
        .out_wd(out_wd), .out_is_load(out_is_load), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Register file with a same-cycle read; entry 0 holds junk so zero-register handling is visible.
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural value of a source: youngest in-flight producer wins, r0 is always zero.
    function automatic logic [31:0] srcVal(input logic [4:0] a, input stim_t s);
        if (a == 5'd0) return 32'd0;
        if (s.exw && !s.exld && s.exwd == a) return s.exdata;
        if (s.memw && s.memwd == a) return s.memdata;
        return regs[a];
    endfunction

    function automatic bit waitsOnLoad(input logic [4:0] a, input stim_t s);
        return a != 5'd0 && s.exw && s.exld && s.exwd == a;
    endfunction

    task automatic applyStimulus(input stim_t s);
        bit   useRt, hz, expReady, accept;
        exp_t e;
        flush = s.flush; out_ready = s.ordy; in_valid = s.v; in_op = s.op;
        in_re1 = s.re1; in_re2 = s.re2; in_rs = s.rs; in_rt = s.rt;
        in_use_imm = s.use_imm; in_imm = s.imm; in_wreg = s.wreg; in_wd = s.wd;
        in_is_load = s.is_load;
        ex_wreg = s.exw; ex_wd = s.exwd; ex_wdata = s.exdata; ex_is_load = s.exld;
        mem_wreg = s.memw; mem_wd = s.memwd; mem_wdata = s.memdata;
        @(negedge clk);
        useRt = s.re2 && !s.use_imm;
        hz = s.v && ((s.re1 && waitsOnLoad(s.rs, s)) || (useRt && waitsOnLoad(s.rt, s)));
        expReady = (!occ || s.ordy) && !hz && !s.flush;
        accept = s.v && expReady;
        checkOutput("re1", {31'd0, re1}, {31'd0, s.v & s.re1});
        checkOutput("re2", {31'd0, re2}, {31'd0, s.v & useRt});
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, expReady});
        checkOutput("stall_cnt", {28'd0, stall_cnt}, modelStall);
        e.op = s.op;
        e.opnd1 = s.re1 ? srcVal(s.rs, s) : 32'd0;
        e.opnd2 = s.use_imm ? s.imm : (useRt ? srcVal(s.rt, s) : 32'd0);
        e.wreg = s.wreg; e.wd = s.wd; e.is_load = s.is_load;
        if (s.flush) occ = 0;
        else if (!occ || s.ordy) occ = accept;
        if (hz && modelStall < 15) modelStall++;
        @(posedge clk);
        if (accept) sb.push_back(e);
        #1;
    endtask

    // Monitor: the front of the queue must be presented until EX takes it or a flush kills it.
    initial begin
        forever begin
            @(negedge clk);
            if (running) begin
                checkOutput("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
                if (out_valid && sb.size() != 0) begin
                    checkOutput("out_op", {24'd0, out_op}, {24'd0, sb[0].op});
                    checkOutput("out_opnd1", out_opnd1, sb[0].opnd1);
                    checkOutput("out_opnd2", out_opnd2, sb[0].opnd2);
                    checkOutput("out_dest", {25'd0, out_wreg, out_wd, out_is_load},
                                {25'd0, sb[0].wreg, sb[0].wd, sb[0].is_load});
                    if (out_ready || flush) void'(sb.pop_front());
                end
            end
        end
    end

    function automatic stim_t randStim();
        stim_t s;
        s.v = $urandom_range(0, 9) < 8;   s.flush = $urandom_range(0, 19) == 0;
        s.ordy = $urandom_range(0, 9) < 7; s.re1 = $urandom_range(0, 3) != 0;
        s.re2 = $urandom_range(0, 3) != 0; s.use_imm = $urandom_range(0, 3) == 0;
        s.wreg = 1'($urandom);  s.is_load = 1'($urandom);  s.op = 8'($urandom);
        s.rs = 5'($urandom_range(0, 7)); s.rt = 5'($urandom_range(0, 7));
        s.wd = 5'($urandom);  s.imm = $urandom;
        s.exw = 1'($urandom); s.exwd = 5'($urandom_range(0, 7)); s.exdata = $urandom;
        s.exld = $urandom_range(0, 9) < 3;
        s.memw = 1'($urandom); s.memwd = 5'($urandom_range(0, 7)); s.memdata = $urandom;
        return s;
    endfunction

    initial begin
        stim_t s, idle;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'hDEADBEEF; regs[3] = 32'h11; regs[4] = 32'h22;
        rst = 1'b1; flush = 0; in_valid = 0; in_op = 0; in_re1 = 0; in_re2 = 0;
        in_rs = 0; in_rt = 0; in_use_imm = 0; in_imm = 0; in_wreg = 0; in_wd = 0;
        in_is_load = 0; ex_wreg = 0; ex_wd = 0; ex_wdata = 0; ex_is_load = 0;
        mem_wreg = 0; mem_wd = 0; mem_wdata = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        checkOutput("reset_opnd1", out_opnd1, 32'd0);
        checkOutput("reset_opnd2", out_opnd2, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        running = 1;
        idle = '0; idle.ordy = 1;

        s = idle; s.v = 1; s.re1 = 1; s.re2 = 1; s.rs = 3; s.rt = 4; s.op = 8'h5A;
        applyStimulus(s);
        s = idle; s.v = 1; s.re1 = 1; s.rs = 5; s.exw = 1; s.exwd = 5; s.exdata = 32'hAA;
        s.memw = 1; s.memwd = 5; s.memdata = 32'hBB;
        applyStimulus(s);
        s.rs = 0; s.exwd = 0; s.memwd = 0;
        applyStimulus(s);
        s = idle; s.v = 1; s.re2 = 1; s.rt = 7; s.exw = 1; s.exld = 1; s.exwd = 7;
        applyStimulus(s);
        applyStimulus(s);
        checkOutput("loaduse_stall_cnt", {28'd0, stall_cnt}, 32'd2);
        s = idle; s.v = 1; s.re1 = 1; s.rs = 4; s.op = 8'h01;
        applyStimulus(s);
        s.ordy = 0; s.op = 8'h02; s.rs = 3;
        repeat (3) applyStimulus(s);
        s.ordy = 1;
        applyStimulus(s);
        s = idle; s.v = 1; s.flush = 1; s.re1 = 1; s.rs = 3;
        applyStimulus(s);
        applyStimulus(idle);

        for (int i = 0; i < 400; i++) applyStimulus(randStim());
        repeat (3) applyStimulus(idle);
        checkOutput("queue_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
